// File: rtl/seg7_mux_scanner.sv
// N-digit multiplexed 7-segment scanner with dead-time blanking and run-time polarity.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_mux_scanner #(
  parameter int unsigned NDIGITS      = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [4*NDIGITS-1:0]   value_in,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   load,
  input  logic                   seg_pol,
  input  logic                   com_pol,
  output logic [7:0]             seg_out,
  output logic [NDIGITS-1:0]     com_out,
  output logic [NDIGITS-1:0]     com_oe,
  output logic                   frame_done
);

  localparam int unsigned CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DIG_W      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned VAL_W      = 4 * NDIGITS;
  localparam int unsigned SLOT_LAST  = PRESCALE - 1;
  localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int unsigned DIG_LAST   = NDIGITS - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DIG_W-1:0]   digit, digit_nxt;
  logic [7:0]         seg_r, seg_nxt;
  logic [NDIGITS-1:0] com_r, com_nxt;
  logic               frame_nxt;

  logic [VAL_W-1:0]   shadow_val, display_val;
  logic [NDIGITS-1:0] shadow_dp, display_dp;
  logic [NDIGITS-1:0] lz_blank;
  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic               frame_end_c;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign cur_nib = display_val[{digit, 2'b00} +: 4];
  assign cur_dp  = display_dp[digit];

  // Leading-zero mask: a digit is blanked only while every more-significant digit is also blank.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic run;
    lz_blank = '0;
    run      = 1'b1;
    for (int i = int'(NDIGITS) - 1; i > 0; i--) begin
      run         = run && (display_val[4*i +: 4] == 4'h0) && !display_dp[i];
      lz_blank[i] = run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign frame_end_c = ena && (state == S_DRIVE) && (cnt == CNT_W'(SLOT_LAST))
                       && (digit == DIG_W'(DIG_LAST));

  // Next-state and next-output logic; ena low forces an immediate blank and IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    digit_nxt = digit;
    seg_nxt   = '0;
    com_nxt   = '0;
    frame_nxt = 1'b0;
    if (!ena) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      digit_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_nxt   = '0;
          digit_nxt = '0;
          state_nxt = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
        end
        S_BLANK: begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BLANK_LAST)) state_nxt = S_DRIVE;
        end
        S_DRIVE: begin
          seg_nxt = {cur_dp, lz_blank[digit] ? 7'h00 : hex7(cur_nib)};
          com_nxt = NDIGITS'(1) << digit;
          if (cnt == CNT_W'(SLOT_LAST)) begin
            cnt_nxt   = '0;
            state_nxt = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
            if (digit == DIG_W'(DIG_LAST)) begin
              digit_nxt = '0;
              frame_nxt = 1'b1;
            end else begin
              digit_nxt = digit + DIG_W'(1);
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          digit_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      digit      <= '0;
      seg_r      <= '0;
      com_r      <= '0;
      com_oe     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit      <= digit_nxt;
      seg_r      <= seg_nxt;
      com_r      <= com_nxt;
      com_oe     <= {NDIGITS{ena}};
      frame_done <= frame_nxt;
    end
  end

  // Shadow captures on load; display only moves at a frame boundary, bypassing a coincident load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val  <= '0;
      shadow_dp   <= '0;
      display_val <= '0;
      display_dp  <= '0;
    end else begin
      if (load) begin
        shadow_val <= value_in;
        shadow_dp  <= dp_in;
      end
      if (frame_end_c) begin
        display_val <= load ? value_in : shadow_val;
        display_dp  <= load ? dp_in    : shadow_dp;
      end
    end
  end

  assign seg_out = seg_pol ? seg_r : ~seg_r;
  assign com_out = com_pol ? com_r : ~com_r;

endmodule
